button_debouncer: RTL

- Input-side counterpart to the LED driver path: conditions a raw, bouncy, asynchronous push-button pin (e.g. BTN_N) into clean, clock-synchronous level and event signals.
- Sits directly behind the top-level pad, inside the PLL clock domain.
- Consumed by application logic such as mode select or blink-rate change.
- Provides press, release and long-press one-cycle pulses plus a debounced level.

---
 rtl/button_pkg.sv | 15 +
 rtl/synchronizer.sv | 24 ++
 rtl/button_debouncer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioning path.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        CHECK_PRESS,
        PRESSED,
        CHECK_RELEASE
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/synchronizer.sv
// Flop-chain synchroniser for an asynchronous pad input; reset loads ResetValue into every stage.
module synchronizer #(
    parameter int unsigned Stages     = 2,
    parameter logic        ResetValue = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] r_sync;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= {Stages{ResetValue}};
        end else begin
            r_sync <= {r_sync[Stages-2:0], d_i};
        end
    end

    assign q_o = r_sync[Stages-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button into a clean level plus press, release and long-press pulses.
module button_debouncer
    import button_pkg::*;
#(
    parameter logic        ActiveLow       = 1'b1,
    parameter int unsigned SyncStages      = 2,
    parameter int unsigned StableCycles    = 160_000,
    parameter int unsigned LongPressCycles = 16_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pressed_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);

    localparam int unsigned StableW = cnt_width(StableCycles);
    localparam int unsigned HoldW   = cnt_width(LongPressCycles);

    localparam logic [StableW-1:0] StableLast = StableW'(StableCycles - 1);
    localparam logic [StableW-1:0] StableMax  = StableW'(StableCycles);
    localparam logic [HoldW-1:0]   HoldLast   = HoldW'(LongPressCycles - 1);
    localparam logic [HoldW-1:0]   HoldMax    = HoldW'(LongPressCycles);

    logic w_btn_sync;
    logic w_btn_s;

    synchronizer #(
        .Stages     (SyncStages),
        .ResetValue (ActiveLow)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (btn_i),
        .q_o   (w_btn_sync)
    );

    assign w_btn_s = w_btn_sync ^ ActiveLow;

    state_e             r_state, w_state_d;
    logic [StableW-1:0] r_stable, w_stable_d;
    logic [HoldW-1:0]   r_hold, w_hold_d;
    logic               r_fired, w_fired_d;
    logic               r_pressed, w_pressed_d;
    logic               r_press, w_press_d;
    logic               r_release, w_release_d;
    logic               r_long, w_long_d;

    always_comb begin
        w_state_d   = r_state;
        w_stable_d  = r_stable;
        w_hold_d    = r_hold;
        w_fired_d   = r_fired;
        w_press_d   = 1'b0;
        w_release_d = 1'b0;
        w_long_d    = 1'b0;

        // Hold time keeps accruing through release bounces so they do not restart it.
        if ((r_state == PRESSED || r_state == CHECK_RELEASE) && r_hold < HoldMax) begin
            w_hold_d = r_hold + 1'b1;
        end

        unique case (r_state)
            RELEASED: begin
                if (w_btn_s) begin
                    w_state_d  = CHECK_PRESS;
                    w_stable_d = StableW'(1);
                end
            end
            CHECK_PRESS: begin
                if (!w_btn_s) begin
                    w_state_d  = RELEASED;
                    w_stable_d = '0;
                end else if (r_stable >= StableLast) begin
                    w_state_d  = PRESSED;
                    w_stable_d = '0;
                    w_hold_d   = '0;
                    w_fired_d  = 1'b0;
                    w_press_d  = 1'b1;
                end else if (r_stable < StableMax) begin
                    w_stable_d = r_stable + 1'b1;
                end
            end
            PRESSED: begin
                if (!w_btn_s) begin
                    w_state_d  = CHECK_RELEASE;
                    w_stable_d = StableW'(1);
                end else if (!r_fired && w_hold_d >= HoldLast) begin
                    w_long_d  = 1'b1;
                    w_fired_d = 1'b1;
                end
            end
            CHECK_RELEASE: begin
                if (w_btn_s) begin
                    w_state_d  = PRESSED;
                    w_stable_d = '0;
                end else if (r_stable >= StableLast) begin
                    w_state_d   = RELEASED;
                    w_stable_d  = '0;
                    w_release_d = 1'b1;
                end else if (r_stable < StableMax) begin
                    w_stable_d = r_stable + 1'b1;
                end
            end
            default: begin
                w_state_d  = RELEASED;
                w_stable_d = '0;
            end
        endcase

        w_pressed_d = (w_state_d == PRESSED) || (w_state_d == CHECK_RELEASE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= RELEASED;
            r_stable  <= '0;
            r_hold    <= '0;
            r_fired   <= 1'b0;
            r_pressed <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_stable  <= w_stable_d;
            r_hold    <= w_hold_d;
            r_fired   <= w_fired_d;
            r_pressed <= w_pressed_d;
            r_press   <= w_press_d;
            r_release <= w_release_d;
            r_long    <= w_long_d;
        end
    end

    assign pressed_o    = r_pressed;
    assign press_o      = r_press;
    assign release_o    = r_release;
    assign long_press_o = r_long;

endmodule
